// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS BCD countdown driven by a 1 Hz one-cycle tick, with expiry flag/pulse.
// Latency: an event sampled at edge N is visible on every output from cycle N+1 (tick-to-display = 1 clk).
// Backpressure: none; every input is a single-cycle request, lower-priority requests in the same cycle are dropped.
//
// Ports:
//   clk, rst        - single clock, synchronous active-high reset
//   tick            - one elapsed second (pulse)
//   load/load_value - load request with BCD {min_tens, min_ones, sec_tens, sec_ones}
//   start/pause     - run control; clear returns to 00:00 / IDLE
//   digits          - current BCD value
//   running/expired - state is RUN / DONE
//   done/err        - one-cycle pulses on expiry / rejected load
module countdown_timer #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    output logic [15:0] digits,
    output logic        running,
    output logic        expired,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state, state_d;
    logic [15:0] rl, rl_d;
    logic [15:0] digits_d;
    logic        done_d, err_d;
    logic        load_ok;

    // One-second BCD decrement. Only used when the value is non-zero, so
    // min_tens never needs to borrow.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] m10, m1, s10, s1;
        {m10, m1, s10, s1} = v;
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1  = 4'd9;
                    m10 = m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    assign load_ok = (load_value[15:12] <= 4'd9) && (load_value[11:8] <= 4'd9) &&
                     (load_value[7:4]   <= 4'd5) && (load_value[3:0]  <= 4'd9);

    // Priority chain: each branch only fires when its request is applicable in
    // the current state, so e.g. a load during RUN falls through to pause/tick.
    always_comb begin
        state_d  = state;
        digits_d = digits;
        rl_d     = rl;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (clear) begin
            digits_d = 16'h0000;
            rl_d     = 16'h0000;
            state_d  = IDLE;
        end else if (load && state != RUN) begin
            if (load_ok) begin
                digits_d = load_value;
                rl_d     = load_value;
                state_d  = IDLE;
            end else begin
                err_d = 1'b1;
            end
        end else if (pause && state == RUN) begin
            state_d = PAUSE;
        end else if (start && (state == IDLE || state == PAUSE) && digits != 16'h0000) begin
            state_d = RUN;
        end else if (tick && state == RUN) begin
            if (digits == 16'h0001) begin
                done_d = 1'b1;
                if (AUTO_RELOAD && rl != 16'h0000) begin
                    digits_d = rl;
                end else begin
                    digits_d = 16'h0000;
                    state_d  = DONE;
                end
            end else begin
                digits_d = bcd_dec(digits);
            end
        end
    end

    // running/expired are registered from the next state so they line up with digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rl      <= 16'h0000;
            digits  <= 16'h0000;
            running <= 1'b0;
            expired <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_d;
            rl      <= rl_d;
            digits  <= digits_d;
            running <= (state_d == RUN);
            expired <= (state_d == DONE);
            done    <= done_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed bench for countdown_timer, one instance per AUTO_RELOAD setting.
// Expected outputs are queued when a step is driven and popped one clock later for checking.
// Both instances share stimulus; each section checks only the instance it targets.
module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_value = 16'h0000;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        clear = 1'b0;

    logic [15:0] digits0, digits1;
    logic        running0, running1, expired0, expired1, done0, done1, err0, err1;

    always #5 clk = ~clk;

    countdown_timer #(.AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .clear(clear),
        .digits(digits0), .running(running0), .expired(expired0), .done(done0), .err(err0)
    );

    countdown_timer #(.AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .load(load), .load_value(load_value),
        .start(start), .pause(pause), .clear(clear),
        .digits(digits1), .running(running1), .expired(expired1), .done(done1), .err(err1)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        run;
        logic        exp;
        logic        dn;
        logic        er;
        logic        ar;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s.%s: got %h expected %h", tag, fld, obs, expv);
        end
    endtask

    // Queue the expectation, let the DUT sample the driven inputs at the next
    // edge, then pop and compare 1 time unit later and release all inputs.
    task automatic step(input string tag, input logic [15:0] d, input logic r, input logic x,
                        input logic dn, input logic er, input logic ar);
        exp_t e;
        e.d = d; e.run = r; e.exp = x; e.dn = dn; e.er = er; e.ar = ar;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.ar) begin
            chk(tag, "digits", digits1, e.d);
            chk(tag, "running", {15'd0, running1}, {15'd0, e.run});
            chk(tag, "expired", {15'd0, expired1}, {15'd0, e.exp});
            chk(tag, "done", {15'd0, done1}, {15'd0, e.dn});
            chk(tag, "err", {15'd0, err1}, {15'd0, e.er});
        end else begin
            chk(tag, "digits", digits0, e.d);
            chk(tag, "running", {15'd0, running0}, {15'd0, e.run});
            chk(tag, "expired", {15'd0, expired0}, {15'd0, e.exp});
            chk(tag, "done", {15'd0, done0}, {15'd0, e.dn});
            chk(tag, "err", {15'd0, err0}, {15'd0, e.er});
        end
        rst = 1'b0; tick = 1'b0; load = 1'b0; load_value = 16'h0000;
        start = 1'b0; pause = 1'b0; clear = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;                         step("reset",      16'h0000, 0, 0, 0, 0, 0);

        // BCD borrow
        load = 1; load_value = 16'h0105;    step("ld0105",     16'h0105, 0, 0, 0, 0, 0);
        start = 1;                          step("start",      16'h0105, 1, 0, 0, 0, 0);
        tick = 1;                           step("t1",         16'h0104, 1, 0, 0, 0, 0);
        tick = 1;                           step("t2",         16'h0103, 1, 0, 0, 0, 0);
        tick = 1;                           step("t3",         16'h0102, 1, 0, 0, 0, 0);
        tick = 1;                           step("t4",         16'h0101, 1, 0, 0, 0, 0);
        tick = 1;                           step("t5",         16'h0100, 1, 0, 0, 0, 0);
        tick = 1;                           step("borrow_min", 16'h0059, 1, 0, 0, 0, 0);
        start = 1;                          step("start_lvl",  16'h0059, 1, 0, 0, 0, 0);

        // Expiry without reload
        rst = 1;                            step("rst2",       16'h0000, 0, 0, 0, 0, 0);
        load = 1; load_value = 16'h0002;    step("ld0002",     16'h0002, 0, 0, 0, 0, 0);
        start = 1;                          step("start2",     16'h0002, 1, 0, 0, 0, 0);
        tick = 1;                           step("e_t1",       16'h0001, 1, 0, 0, 0, 0);
        tick = 1;                           step("expire",     16'h0000, 0, 1, 1, 0, 0);
                                            step("done_1cyc",  16'h0000, 0, 1, 0, 0, 0);
        tick = 1;                           step("done_tick",  16'h0000, 0, 1, 0, 0, 0);
        start = 1;                          step("done_start", 16'h0000, 0, 1, 0, 0, 0);
        load = 1; load_value = 16'h0010;    step("done_load",  16'h0010, 0, 0, 0, 0, 0);

        // Pause priority over tick
        load = 1; load_value = 16'h0030;    step("ld0030",     16'h0030, 0, 0, 0, 0, 0);
        start = 1;                          step("start3",     16'h0030, 1, 0, 0, 0, 0);
        pause = 1; tick = 1;                step("pause_tick", 16'h0030, 0, 0, 0, 0, 0);
        tick = 1;                           step("pause_hold", 16'h0030, 0, 0, 0, 0, 0);
        start = 1;                          step("resume",     16'h0030, 1, 0, 0, 0, 0);
        tick = 1;                           step("borrow_sec", 16'h0029, 1, 0, 0, 0, 0);

        // Load validation
        load = 1; load_value = 16'h0100;    step("ld_in_run",  16'h0029, 1, 0, 0, 0, 0);
        clear = 1;                          step("clear1",     16'h0000, 0, 0, 0, 0, 0);
        load = 1; load_value = 16'h0A00;    step("bad_min",    16'h0000, 0, 0, 0, 1, 0);
                                            step("err_1cyc",   16'h0000, 0, 0, 0, 0, 0);
        load = 1; load_value = 16'h0060;    step("bad_sec10",  16'h0000, 0, 0, 0, 1, 0);
        load = 1; load_value = 16'h9959;    step("ld_max",     16'h9959, 0, 0, 0, 0, 0);
        start = 1;                          step("start_max",  16'h9959, 1, 0, 0, 0, 0);
        tick = 1;                           step("max_tick",   16'h9958, 1, 0, 0, 0, 0);
        pause = 1;                          step("pause2",     16'h9958, 0, 0, 0, 0, 0);
        load = 1; load_value = 16'h1000;    step("ld1000",     16'h1000, 0, 0, 0, 0, 0);
        start = 1;                          step("start4",     16'h1000, 1, 0, 0, 0, 0);
        tick = 1;                           step("borrow_m10", 16'h0959, 1, 0, 0, 0, 0);

        // Clear and reset mid-run
        pause = 1;                          step("pause3",     16'h0959, 0, 0, 0, 0, 0);
        load = 1; load_value = 16'h0145;    step("ld0145",     16'h0145, 0, 0, 0, 0, 0);
        start = 1;                          step("start5",     16'h0145, 1, 0, 0, 0, 0);
        clear = 1; tick = 1;                step("clear_run",  16'h0000, 0, 0, 0, 0, 0);
        start = 1;                          step("start_zero", 16'h0000, 0, 0, 0, 0, 0);
        load = 1; load_value = 16'h0001;    step("ld0001",     16'h0001, 0, 0, 0, 0, 0);
        start = 1;                          step("start6",     16'h0001, 1, 0, 0, 0, 0);
        clear = 1; tick = 1;                step("clear_exp",  16'h0000, 0, 0, 0, 0, 0);
        load = 1; load_value = 16'h0005;    step("ld0005",     16'h0005, 0, 0, 0, 0, 0);
        start = 1;                          step("start7",     16'h0005, 1, 0, 0, 0, 0);
        tick = 1;                           step("t_0004",     16'h0004, 1, 0, 0, 0, 0);
        rst = 1; tick = 1;                  step("rst_run",    16'h0000, 0, 0, 0, 0, 0);

        // Auto-reload instance
        rst = 1;                            step("ar_rst",     16'h0000, 0, 0, 0, 0, 1);
        load = 1; load_value = 16'h0003;    step("ar_ld",      16'h0003, 0, 0, 0, 0, 1);
        start = 1;                          step("ar_start",   16'h0003, 1, 0, 0, 0, 1);
        tick = 1;                           step("ar_t1",      16'h0002, 1, 0, 0, 0, 1);
        tick = 1;                           step("ar_t2",      16'h0001, 1, 0, 0, 0, 1);
        tick = 1;                           step("ar_done1",   16'h0003, 1, 0, 1, 0, 1);
        tick = 1;                           step("ar_t4",      16'h0002, 1, 0, 0, 0, 1);
        tick = 1;                           step("ar_t5",      16'h0001, 1, 0, 0, 0, 1);
        tick = 1;                           step("ar_done2",   16'h0003, 1, 0, 1, 0, 1);
                                            step("ar_idle",    16'h0003, 1, 0, 0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Minutes:seconds BCD countdown timer driven by the one-cycle `tick` pulse of the upstream clock divider (configured for a 1 Hz tick). It holds a loaded MM:SS value, decrements it by one second per tick while running, and flags expiry. Its outputs feed the seven-segment display driver and the board-level control logic.

## Interface
- `AUTO_RELOAD`, default 0: when 1, the block reloads the last loaded value on expiry and keeps running.
- `clk` input 1: system clock. The block uses one clock. Reset is synchronous and active-high.
- `rst` input 1: synchronous, active-high reset.
- `tick` input 1: one-cycle pulse from the clock divider. Each pulse means one elapsed second.
- `load` input 1: load request.
- `load_value` input 16: BCD value {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- `start` input 1: start or resume request (level or pulse).
- `pause` input 1: pause request.
- `clear` input 1: return to 00:00 and the IDLE state.
- `digits` output 16: current BCD value, same packing as `load_value`.
- `running` output 1: high when the state is RUN.
- `expired` output 1: high when the state is DONE.
- `done` output 1: one-cycle pulse on expiry.
- `err` output 1: one-cycle pulse when a load is rejected.

## Operation
- States are IDLE, RUN, PAUSE and DONE. There is a 16-bit reload register `rl`, which is internal.
- All outputs are registered. On `rst`, every output is 0, `rl` is 0 and the state is IDLE.
- Input priority per cycle: `rst` > `clear` > `load` > `pause` > `start` > `tick`. Only the highest-priority applicable event takes effect; all lower ones are dropped.
- `clear` (any state): `digits` = 0, `rl` = 0, state goes to IDLE.
- `load`:
  - Honoured only in IDLE, PAUSE or DONE. Ignored in RUN, and `err` is not raised.
  - A valid value has every digit ≤ 9 and sec_tens ≤ 5.
  - Valid: `digits` ← `load_value`, `rl` ← `load_value`, state goes to IDLE.
  - Invalid: `digits`, `rl` and the state are unchanged, and `err` pulses.
- `pause`: in RUN the state goes to PAUSE. In any other state it has no effect.
- `start`:
  - IDLE or PAUSE with `digits` ≠ 0: state goes to RUN.
  - `digits` = 0: ignored.
  - In DONE: ignored.
- `tick` in RUN: `digits` is decremented by 1 second as BCD.
  - sec_ones borrows 0→9. sec_tens borrows 0→5.
  - min_ones borrows 0→9. min_tens decrements.
  - `tick` is ignored in every state other than RUN.
- Expiry is the tick that takes `digits` from 00:01 to 00:00. `done` pulses.
  - `AUTO_RELOAD` = 0: `digits` = 0 and the state goes to DONE.
  - `AUTO_RELOAD` = 1: `digits` ← `rl` and the state stays RUN. If `rl` = 0, the state goes to DONE instead.
- Maximum value is 99:59. No wrap below 00:00 is possible.

## Timing
- An event sampled at edge N updates `digits` and the state at edge N, so the result is visible from cycle N+1.
- `running` and `expired` follow the state with the same timing as `digits`.
- `done` and `err` are high for exactly cycle N+1 after the triggering edge N.
- Tick-to-display latency is 1 clock.
- Back-to-back ticks on consecutive cycles each decrement. The block relies on no minimum tick spacing.
- `rst` or `clear` asserted mid-run takes effect at the next edge. A pending `done` is not produced.

## Test plan
- **BCD borrow:** rst; load 0x0105; start; 5 ticks → `digits` = 0x0100. One more tick → 0x0059, `running` = 1.
- **Expiry (AUTO_RELOAD=0):** load 0x0002; start; 2 ticks → one-cycle `done`; `digits` = 0x0000, `expired` = 1, `running` = 0. Further ticks and start → no change. Load 0x0010 → IDLE, `digits` = 0x0010.
- **Pause priority:** in RUN at 0x0030, assert `pause` and `tick` in the same cycle → `digits` stays 0x0030, state is PAUSE. Ticks in PAUSE → no change. Start then 1 tick → 0x0029.
- **Load validation:**
  - In IDLE: load 0x0A00 → `err` pulse, `digits` unchanged. Load 0x0060 → `err` pulse. Load 0x9959 → accepted.
  - In RUN: load 0x0100 → ignored, no `err`.
- **Auto-reload (AUTO_RELOAD=1):** load 0x0003; start; 3 ticks → `done` pulse; `digits` = 0x0003, `running` stays 1. 3 more ticks → second `done`.
- **Clear and reset mid-run:** RUN at 0x0145; `clear` → next cycle `digits` = 0, state IDLE. Start → stays IDLE. Load 0x0005, start, assert `rst` → all outputs 0 next cycle.
